// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// Widths, the display ceiling and the per-digit leading-zero thresholds
// match the downstream 4-digit decoder.
package sseg_scan_ctrl_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIG_SEL_W  = 2;
    localparam int unsigned NUM_W      = 14;

    localparam logic [NUM_W-1:0] NUM_MAX  = 14'd9999;
    localparam logic [NUM_W-1:0] THR_TENS = 14'd10;
    localparam logic [NUM_W-1:0] THR_HUND = 14'd100;
    localparam logic [NUM_W-1:0] THR_THOU = 14'd1000;

    localparam logic [DIG_SEL_W-1:0] DIG_ONES = 2'd0;
    localparam logic [DIG_SEL_W-1:0] DIG_TENS = 2'd1;
    localparam logic [DIG_SEL_W-1:0] DIG_HUND = 2'd2;
    localparam logic [DIG_SEL_W-1:0] DIG_THOU = 2'd3;

    // Clamp a raw binary value to the largest value four digits can show.
    function automatic logic [NUM_W-1:0] sat_num(input logic [NUM_W-1:0] v);
        return (v > NUM_MAX) ? NUM_MAX : v;
    endfunction

    // True when the selected digit is a leading zero of v. The ones digit is
    // never a leading zero, so a value of 0 still shows a single "0".
    function automatic logic is_lead_zero(input logic [DIG_SEL_W-1:0] sel,
                                          input logic [NUM_W-1:0]     v);
        logic lz;
        lz = 1'b0;
        unique case (sel)
            DIG_THOU: lz = (v < THR_THOU);
            DIG_HUND: lz = (v < THR_HUND);
            DIG_TENS: lz = (v < THR_TENS);
            DIG_ONES: lz = 1'b0;
            default:  lz = 1'b0;
        endcase
        return lz;
    endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Value handshake between a producer and the scan controller.
//   num_in    : binary value to display (unsigned)
//   num_valid : num_in is valid this cycle
//   num_ready : consumer can take num_in this cycle
// A transfer happens in a cycle where num_valid and num_ready are both 1.
interface sseg_scan_ctrl_if;
    import sseg_scan_ctrl_pkg::*;

    logic [NUM_W-1:0] num_in;
    logic             num_valid;
    logic             num_ready;

    modport master (
        output num_in,
        output num_valid,
        input  num_ready
    );

    modport slave (
        input  num_in,
        input  num_valid,
        output num_ready
    );

endinterface

// File: rtl/sseg_scan_ctrl_tick_gen.sv
// Prescaler producing a single-cycle tick once every DIV enabled cycles.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   en    : 1 = count; 0 = hold the count at 0, no tick
//   tick  : high in the cycle the count equals DIV-1
// Dropping en restarts the period, so re-enabling gives a full DIV cycles.
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == CntLast);
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Feeder for a 4-digit multiplexed seven-segment decoder.
// Takes a value over a valid/ready handshake, saturates it to 9999, parks it
// in a one-entry pending slot and commits it to num_out only at a frame
// boundary so a frame never shows a mix of old and new digits. Scans dig_sel
// 0..3 at the per-digit refresh rate and generates per-digit blanking.
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   num_if     : slave side of the value handshake
//   enable     : 1 = scan; 0 = freeze dig_sel and blank the display
//   blank_lz   : 1 = blank leading zeros
//   num_out    : frame-stable value to the decoder, always <= 9999
//   dig_sel    : active digit, 0 = ones
//   dig_blank  : 1 = force the current digit dark
//   frame_done : one-cycle pulse coincident with dig_sel wrapping 3 -> 0
module sseg_scan_ctrl
    import sseg_scan_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned REFRESH_HZ = 1_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sseg_scan_ctrl_if.slave      num_if,
    input  logic                 enable,
    input  logic                 blank_lz,
    output logic [NUM_W-1:0]     num_out,
    output logic [DIG_SEL_W-1:0] dig_sel,
    output logic                 dig_blank,
    output logic                 frame_done
);

    localparam int unsigned TICK_DIV = CLK_HZ / REFRESH_HZ;

    logic                 tick;
    logic                 accept;
    logic                 frame_end;
    logic                 commit;

    logic [DIG_SEL_W-1:0] dig_sel_q, dig_sel_d;
    logic [NUM_W-1:0]     num_out_q, num_out_d;
    logic [NUM_W-1:0]     pend_q, pend_d;
    logic                 pend_full_q, pend_full_d;
    logic                 frame_done_q;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (enable),
        .tick  (tick)
    );

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    assign num_if.num_ready = rst_n && !pend_full_q;
    assign accept           = num_if.num_valid && num_if.num_ready;

    // The last digit's tick closes the frame; that is the only commit point.
    assign frame_end = tick && (dig_sel_q == DIG_THOU);
    assign commit    = frame_end && pend_full_q;

    always_comb begin
        dig_sel_d   = dig_sel_q;
        num_out_d   = num_out_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;

        if (tick) begin
            dig_sel_d = dig_sel_q + 1'b1;  // 3 wraps to 0
        end

        // accept and commit are mutually exclusive: accept needs an empty
        // slot, commit needs a full one.
        if (accept) begin
            pend_d      = sat_num(num_if.num_in);
            pend_full_d = 1'b1;
        end else if (commit) begin
            num_out_d   = pend_q;
            pend_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dig_sel_q    <= '0;
            num_out_q    <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            dig_sel_q    <= dig_sel_d;
            num_out_q    <= num_out_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            frame_done_q <= frame_end;
        end
    end

    assign num_out    = num_out_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;
    assign dig_blank  = !enable || (blank_lz && is_lead_zero(dig_sel_q, num_out_q));

endmodule
